// File: rtl/decode_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU operation codes and
// the layout of the 9-bit control word handed to EX.
package decode_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [2:0] {
    ALUOP_NONE  = 3'b000,
    ALUOP_ADD   = 3'b001,
    ALUOP_SUB   = 3'b010,
    ALUOP_RTYPE = 3'b100
  } alu_op_e;

  // Field order fixes the o_ctrl bit positions, MSB first.
  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    reg_dst;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

endpackage

// File: rtl/instruction_decode_if.sv
// Fetch/writeback/EX-facing signals of the decode stage; the decode block
// itself connects through the slave modport.
interface instruction_decode_if #(
  parameter int NBITS = 32
);
  logic [NBITS-1:0] i_pc_4;
  logic [NBITS-1:0] i_instruccion;
  logic             i_RegWrite_wb;
  logic [4:0]       i_wAddr_wb;
  logic [NBITS-1:0] i_wData_wb;
  logic             i_MemRead_ex;
  logic [4:0]       i_rt_ex;

  logic             o_PCWrite;
  logic             o_PCSource;
  logic [NBITS-1:0] o_DstSalto;
  logic [NBITS-1:0] o_pc_4;
  logic [NBITS-1:0] o_rs_data;
  logic [NBITS-1:0] o_rt_data;
  logic [NBITS-1:0] o_imm;
  logic [4:0]       o_rs;
  logic [4:0]       o_rt;
  logic [4:0]       o_rd;
  logic [8:0]       o_ctrl;

  modport master (
    output i_pc_4, i_instruccion, i_RegWrite_wb, i_wAddr_wb, i_wData_wb,
           i_MemRead_ex, i_rt_ex,
    input  o_PCWrite, o_PCSource, o_DstSalto, o_pc_4, o_rs_data, o_rt_data,
           o_imm, o_rs, o_rt, o_rd, o_ctrl
  );

  modport slave (
    input  i_pc_4, i_instruccion, i_RegWrite_wb, i_wAddr_wb, i_wData_wb,
           i_MemRead_ex, i_rt_ex,
    output o_PCWrite, o_PCSource, o_DstSalto, o_pc_4, o_rs_data, o_rt_data,
           o_imm, o_rs, o_rt, o_rd, o_ctrl
  );
endinterface

// File: rtl/register_file.sv
// Two-read, one-write register file with r0 hard-wired to zero.
// ID_REGFILE_BYPASS_EN: same-cycle write data is forwarded to the read ports.
module register_file #(
  parameter int NBITS = 32,
  parameter int NREG  = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_we,
  input  logic [4:0]       i_waddr,
  input  logic [NBITS-1:0] i_wdata,
  input  logic [4:0]       i_raddr_a,
  input  logic [4:0]       i_raddr_b,
  output logic [NBITS-1:0] o_rdata_a,
  output logic [NBITS-1:0] o_rdata_b
);

  logic [NBITS-1:0] regs [NREG];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata_a = '0;
    o_rdata_b = '0;
    if (i_raddr_a != '0) begin
`ifdef ID_REGFILE_BYPASS_EN
      o_rdata_a = (i_we && (i_waddr == i_raddr_a)) ? i_wdata : regs[i_raddr_a];
`else
      o_rdata_a = regs[i_raddr_a];
`endif
    end
    if (i_raddr_b != '0) begin
`ifdef ID_REGFILE_BYPASS_EN
      o_rdata_b = (i_we && (i_waddr == i_raddr_b)) ? i_wdata : regs[i_raddr_b];
`else
      o_rdata_b = regs[i_raddr_b];
`endif
    end
  end

endmodule

// File: rtl/instruction_decode.sv
// ID stage: control decode, load-use hazard detection, branch/jump resolution
// and the ID/EX pipeline register. Regfile write-through via ID_REGFILE_BYPASS_EN.
module instruction_decode #(
  parameter int NBITS = 32,
  parameter int NREG  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  instruction_decode_if.slave  bus
);
  import decode_pkg::*;

  logic [NBITS-1:0] instr;
  logic [5:0]       opcode;
  logic [4:0]       rs, rt, rd;
  logic [NBITS-1:0] imm;
  logic [NBITS-1:0] rs_data, rt_data;
  logic [NBITS-1:0] br_target, j_target;
  ctrl_t            ctrl;
  logic             uses_rt, is_beq, is_bne, is_j;
  logic             stall, taken;

  assign instr  = bus.i_instruccion;
  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign imm    = {{(NBITS-16){instr[15]}}, instr[15:0]};

  register_file #(
    .NBITS (NBITS),
    .NREG  (NREG)
  ) u_register_file (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_we      (bus.i_RegWrite_wb),
    .i_waddr   (bus.i_wAddr_wb),
    .i_wdata   (bus.i_wData_wb),
    .i_raddr_a (rs),
    .i_raddr_b (rt),
    .o_rdata_a (rs_data),
    .o_rdata_b (rt_data)
  );

  always_comb begin
    ctrl    = '0;
    uses_rt = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.alu_op    = ALUOP_RTYPE;
        uses_rt        = 1'b1;
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        uses_rt        = 1'b1;
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALUOP_SUB;
        uses_rt     = 1'b1;
        is_beq      = 1'b1;
      end
      OP_BNE: begin
        ctrl.alu_op = ALUOP_SUB;
        uses_rt     = 1'b1;
        is_bne      = 1'b1;
      end
      OP_J: is_j = 1'b1;
      default: ;
    endcase
  end

  // rs is compared for every opcode; rt only where it is a true source operand.
  always_comb begin
    stall = bus.i_MemRead_ex && (bus.i_rt_ex != '0) &&
            ((bus.i_rt_ex == rs) || (uses_rt && (bus.i_rt_ex == rt)));
  end

  always_comb begin
    br_target = bus.i_pc_4 + imm;
    j_target  = {bus.i_pc_4[NBITS-1:26], instr[25:0]};
    taken     = !i_reset && !stall &&
                (is_j || (is_beq && (rs_data == rt_data)) ||
                         (is_bne && (rs_data != rt_data)));
    bus.o_PCWrite  = i_reset || !stall;
    bus.o_PCSource = !taken;
    bus.o_DstSalto = '0;
    if (taken) begin
      bus.o_DstSalto = is_j ? j_target : br_target;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset || stall) begin
      bus.o_pc_4    <= '0;
      bus.o_rs_data <= '0;
      bus.o_rt_data <= '0;
      bus.o_imm     <= '0;
      bus.o_rs      <= '0;
      bus.o_rt      <= '0;
      bus.o_rd      <= '0;
      bus.o_ctrl    <= '0;
    end else begin
      bus.o_pc_4    <= bus.i_pc_4;
      bus.o_rs_data <= rs_data;
      bus.o_rt_data <= rt_data;
      bus.o_imm     <= imm;
      bus.o_rs      <= rs;
      bus.o_rt      <= rt;
      bus.o_rd      <= rd;
      bus.o_ctrl    <= ctrl;
    end
  end

endmodule
